// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-way valid/ready multiplexer.
// Holds the mode encoding and the round-robin start-index function.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  // Compare-and-reset wrap, since N need not be a power of two.
  function automatic int unsigned rr_start(
    input int unsigned ptr,
    input int unsigned n
  );
    return (ptr + 1 == n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mux_nway_rr_if.sv
// Stream bundle between N producers, the mux, and one consumer.
// master drives inputs and consumes the output; slave is the mux.
interface mux_nway_rr_if #(
  parameter int N = 8,
  parameter int W = 1
);
  import mux_pkg::*;

  localparam int SEL_W = $clog2(N);

  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  mux_mode_t        mode;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_chan;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational rotating-priority encoder.
// Scans req from ptr+1 upward with wrap and returns the first hit.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [SEL_W-1:0] idx;

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = SEL_W'(rr_start(32'(ptr), N));
    for (int k = 0; k < N; k++) begin
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
      idx = (idx == SEL_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/mux_nway_rr.sv
// N-channel W-bit mux, fixed-select or round-robin, with a
// single registered output stage giving one word per cycle.
module mux_nway_rr
  import mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N)
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_nway_rr_if.slave bus
);

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [SEL_W-1:0] rr_idx, gnt_idx;
  logic             rr_vld, fix_vld, gnt_vld;
  logic             load, xfer;
  logic [N-1:0]     rdy;

  rr_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
    .req      (bus.in_valid),
    .ptr      (ptr_q),
    .gnt_idx  (rr_idx),
    .gnt_valid(rr_vld)
  );

  always_comb begin
    fix_vld = 1'b0;
    if (int'(bus.sel) < N) fix_vld = bus.in_valid[bus.sel];
    gnt_idx = '0;
    gnt_vld = 1'b0;
    unique case (bus.mode)
      MODE_RR: begin
        gnt_idx = rr_idx;
        gnt_vld = rr_vld;
      end
      MODE_FIXED: begin
        gnt_idx = bus.sel;
        gnt_vld = fix_vld;
      end
      default: ;
    endcase
  end

  assign load = !out_valid_q || bus.out_ready;
  assign xfer = rst_n && load && gnt_vld;

  always_comb begin
    rdy = '0;
    if (xfer) rdy[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_data_d = bus.in_data[int'(gnt_idx)*W +: W];
      out_chan_d = gnt_idx;
      if (bus.mode == MODE_RR) ptr_d = gnt_idx;
    end
  end

  // ptr resets to N-1 so channel 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= SEL_W'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nway_rr.sv
// Bench for mux_nway_rr: directed scenarios on N=8 and N=6 instances
// plus randomized traffic against a behavioural reference model.
module tb_mux_nway_rr;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_nway_rr_if #(.N(8), .W(4)) if8();
  mux_nway_rr_if #(.N(6), .W(4)) if6();

  mux_nway_rr #(.N(8), .W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave)
  );
  mux_nway_rr #(.N(6), .W(4)) u6 (
    .clk(clk), .rst_n(rst_n), .bus(if6.slave)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if8.in_valid = '1; if8.mode = MODE_RR; if8.sel = '0;
    if8.out_ready = 1'b1; if8.in_data = '0;
    if6.in_valid = '1; if6.mode = MODE_RR; if6.sel = '0;
    if6.out_ready = 1'b1; if6.in_data = '0;
    rst_n = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 8'h00) begin
      errors++;
      $display("FAIL rst_ready8 got=%h exp=00", if8.in_ready);
    end
    checks++;
    if (if6.in_ready !== 6'h00) begin
      errors++;
      $display("FAIL rst_ready6 got=%h exp=00", if6.in_ready);
    end
    if8.in_valid = '0; if6.in_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    checks++;
    if ({if8.out_valid, if8.out_data, if8.out_chan, if8.in_ready} !== '0) begin
      errors++;
      $display("FAIL reset8 got v=%b d=%h c=%0d r=%h exp all 0",
        if8.out_valid, if8.out_data, if8.out_chan, if8.in_ready);
    end
    checks++;
    if ({if6.out_valid, if6.out_data, if6.out_chan} !== '0) begin
      errors++;
      $display("FAIL reset6 got v=%b d=%h c=%0d exp all 0",
        if6.out_valid, if6.out_data, if6.out_chan);
    end
  endtask

  task automatic test_fixed();
    if8.mode = MODE_FIXED;
    for (int i = 0; i < 8; i++) if8.in_data[i*4 +: 4] = 4'(i + 3);
    if8.in_valid = '1;
    for (int s = 0; s < 8; s++) begin
      if8.sel = 3'(s);
      @(negedge clk);
      checks++;
      if (if8.in_ready !== 8'(1 << s)) begin
        errors++;
        $display("FAIL fixed_ready sel=%0d got=%h exp=%h",
          s, if8.in_ready, 8'(1 << s));
      end
      cyc();
      checks++;
      if (if8.out_valid !== 1'b1 || if8.out_data !== 4'(s + 3) ||
          if8.out_chan !== 3'(s)) begin
        errors++;
        $display("FAIL fixed_out sel=%0d got v=%b d=%h c=%0d exp v=1 d=%h c=%0d",
          s, if8.out_valid, if8.out_data, if8.out_chan, 4'(s + 3), s);
      end
    end
  endtask

  task automatic test_fixed_oob();
    if6.mode = MODE_FIXED;
    if6.sel = 3'd7;
    if6.in_valid = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (if6.in_ready !== 6'h00 || if6.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL fixed_oob cyc=%0d got r=%h v=%b exp r=00 v=0",
          i, if6.in_ready, if6.out_valid);
      end
      cyc();
    end
    if6.in_valid = '0;
  endtask

  task automatic test_rr_seq(input logic [7:0] vld, input int n,
                             input int first, input string nm);
    int exp_c;
    if8.mode = MODE_RR;
    if8.in_valid = vld;
    exp_c = first;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++;
      if (if8.in_ready !== 8'(1 << exp_c)) begin
        errors++;
        $display("FAIL %s_ready k=%0d got=%h exp=%h",
          nm, k, if8.in_ready, 8'(1 << exp_c));
      end
      cyc();
      checks++;
      if (if8.out_chan !== 3'(exp_c) || if8.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s_chan k=%0d got=%0d exp=%0d",
          nm, k, if8.out_chan, exp_c);
      end
      for (int j = 1; j <= 8; j++) begin
        if (vld[(exp_c + j) % 8]) begin
          exp_c = (exp_c + j) % 8;
          break;
        end
      end
    end
  endtask

  task automatic test_backpressure();
    if8.mode = MODE_RR;
    if8.in_data[3*4 +: 4] = 4'hA;
    if8.in_valid = 8'b0000_1000;
    if8.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 8'h08) begin
      errors++;
      $display("FAIL bp_load got=%h exp=08", if8.in_ready);
    end
    cyc();
    if8.out_ready = 1'b0;
    if8.in_valid = '1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (if8.in_ready !== 8'h00 || if8.out_data !== 4'hA ||
          if8.out_chan !== 3'd3 || if8.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold i=%0d got r=%h d=%h c=%0d v=%b exp r=00 d=a c=3 v=1",
          i, if8.in_ready, if8.out_data, if8.out_chan, if8.out_valid);
      end
      cyc();
    end
    if8.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 8'h10) begin
      errors++;
      $display("FAIL bp_release got=%h exp=10", if8.in_ready);
    end
    cyc();
    checks++;
    if (if8.out_chan !== 3'd4 || if8.out_data !== 4'h7) begin
      errors++;
      $display("FAIL bp_next got c=%0d d=%h exp c=4 d=7",
        if8.out_chan, if8.out_data);
    end
  endtask

  task automatic test_reset_mid();
    if8.out_ready = 1'b0;
    if8.in_valid = '1;
    cyc();
    checks++;
    if (if8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got v=%b exp=1", if8.out_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 8'h00) begin
      errors++;
      $display("FAIL mid_rdy got=%h exp=00", if8.in_ready);
    end
    cyc();
    rst_n = 1'b1;
    checks++;
    if (if8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_valid got=%b exp=0", if8.out_valid);
    end
    if8.out_ready = 1'b1;
    if8.mode = MODE_RR;
    @(negedge clk);
    checks++;
    if (if8.in_ready !== 8'h01) begin
      errors++;
      $display("FAIL mid_first got=%h exp=01", if8.in_ready);
    end
    cyc();
    checks++;
    if (if8.out_chan !== 3'd0 || if8.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_chan got c=%0d v=%b exp c=0 v=1",
        if8.out_chan, if8.out_valid);
    end
  endtask

  task automatic test_random();
    bit       m_v;
    int       m_d, m_c, m_p;
    bit       gv, ld;
    int       gi;
    logic [7:0] e_rdy;
    rst_n = 1'b0;
    if8.in_valid = '0;
    cyc();
    rst_n = 1'b1;
    m_v = 0; m_d = 0; m_c = 0; m_p = 7;
    for (int t = 0; t < 400; t++) begin
      if8.in_data   = $urandom;
      if8.in_valid  = 8'($urandom & $urandom);
      if8.mode      = mux_mode_t'($urandom_range(0, 1));
      if8.sel       = 3'($urandom_range(0, 7));
      if8.out_ready = ($urandom_range(0, 3) != 0);
      gv = 0; gi = 0;
      if (if8.mode == MODE_FIXED) begin
        if (if8.in_valid[if8.sel]) begin gv = 1; gi = if8.sel; end
      end else begin
        for (int k = 1; k <= 8; k++) begin
          if (!gv && if8.in_valid[(m_p + k) % 8]) begin
            gv = 1; gi = (m_p + k) % 8;
          end
        end
      end
      ld = !m_v || if8.out_ready;
      e_rdy = (ld && gv) ? 8'(1 << gi) : 8'h00;
      @(negedge clk);
      checks++;
      if (if8.in_ready !== e_rdy) begin
        errors++;
        $display("FAIL rand_ready t=%0d got=%h exp=%h", t, if8.in_ready, e_rdy);
      end
      if (ld) begin
        m_v = gv;
        if (gv) begin
          m_d = (if8.in_data >> (gi * 4)) & 4'hF;
          m_c = gi;
          if (if8.mode == MODE_RR) m_p = gi;
        end
      end
      cyc();
      checks++;
      if (if8.out_valid !== m_v ||
          (m_v && (if8.out_data !== 4'(m_d) || if8.out_chan !== 3'(m_c)))) begin
        errors++;
        $display("FAIL rand_out t=%0d got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
          t, if8.out_valid, if8.out_data, if8.out_chan, m_v, m_d, m_c);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed();
    test_fixed_oob();
    test_rr_seq(8'hFF, 9, 0, "rr_all");
    test_rr_seq(8'b0010_0100, 4, 2, "rr_sparse");
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_nway_rr.md
Name: mux_nway_rr

Overview:
Parametrised N-channel, W-bit multiplexer with per-channel valid/ready inputs and a registered valid/ready output. It generalises the fixed 8-way 1-bit select mux. Two modes are supported: fixed select, where a channel index drives the choice, and round-robin, where a rotating-priority scan picks the channel. The block sits between multiple producer streams and a single consumer, for example as a bus or port funnel.

Parameters:
N, 8, number of input channels (N >= 2)
W, 1, data width per channel in bits
SEL_W, $clog2(N), width of the channel index (derived; not to be overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept, one-hot or all zero
mode  input  1  0 = MODE_FIXED, 1 = MODE_RR
sel  input  SEL_W  channel index used in MODE_FIXED; ignored in MODE_RR
out_data  output  W  registered selected data
out_chan  output  SEL_W  index of the channel that produced out_data
out_valid  output  1  output register holds data
out_ready  input  1  consumer accepts when high together with out_valid

Behaviour:
- Reset (rst_n low at a clk edge): out_valid=0, out_data=0, out_chan=0, RR pointer ptr=N-1, so channel 0 has first priority. in_ready is all zero while rst_n is low.
- Reset mid-transfer discards any held output word. No handshake completes in a cycle where rst_n is low.
- load = !out_valid || out_ready. The single output register may refill in the same cycle it drains, giving 1 word per cycle throughput.
- Grant, combinational each cycle:
  - MODE_FIXED: grant channel sel only if sel < N and in_valid[sel]. If sel >= N there is no grant; this replaces the old undefined output.
  - MODE_RR: grant the first i with in_valid[i] asserted, scanning (ptr+1) mod N upward with wrap-around. If no channel is valid there is no grant.
- in_ready[g] = load && grant_valid, only for the granted g; all other bits are 0.
- Transfer when in_valid[g] && in_ready[g]. At the next edge: out_data = in_data[g], out_chan = g, out_valid = 1.
- Latency: 1 cycle from input handshake to out_valid.
- If load is high and there is no grant, out_valid falls to 0 at the next edge if the current word was consumed; otherwise it holds.
- Backpressure: while out_valid && !out_ready, out_data and out_chan hold stable and in_ready is all zero.
- ptr updates to g only on an RR-mode transfer. In fixed mode ptr holds.
- Mode or sel changes take effect on the next grant evaluation. They never alter a word already held in the output register.
- in_valid deasserting without a handshake is legal, with no state effect.
- Data width is pure pass-through. There is no arithmetic except the modulo-N index wrap, done with SEL_W-bit compare-and-reset, not a power-of-2 mask, because N need not be a power of 2.

Decomposition:
- Package mux_pkg holds:
  - typedef enum logic {MODE_FIXED, MODE_RR} mux_mode_t
  - a function computing the rotated start index (ptr+1 == N ? 0 : ptr+1).
- One sub-module, rr_pick: a combinational rotating-priority encoder.
  - Parameter: N.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_valid.
  - Instantiated once in mux_nway_rr. The registered output stage stays in the top module.

Test Plan:
1. Reset, N=8, W=4, out_ready=1: after rst_n deasserts, out_valid=0, out_data=0, out_chan=0, in_ready=0 with all in_valid low.
2. MODE_FIXED, in_data channel i = i+3, all valid, sel stepping 0..7: one cycle later each out_data=sel+3 and out_chan=sel. in_ready is one-hot at bit sel.
3. N=6, MODE_FIXED, sel=7 with all valid: in_ready=0 and out_valid stays 0 for 10 cycles.
4. MODE_RR, N=8, all in_valid held high, out_ready=1: out_chan sequence is 0,1,...,7,0 on consecutive cycles. in_valid={only 2,5}: sequence is 2,5,2,5.
5. Backpressure: hold out_ready=0 for 4 cycles after a word from channel 3 (data 0xA). out_data=0xA and out_chan=3 stay stable and in_ready=0. On release, the next channel (4) is granted in the same cycle as the drain.
6. Assert rst_n=0 for one cycle while out_valid=1 and out_ready=0: out_valid=0 next cycle. The first RR grant after reset is channel 0.
